poststore_writer: RTL and testbench

- Write-back counterpart of the HP-port read prefetcher.
- Drains a result ping-pong buffer (buffer0/buffer1) to DDR over the HP write port, one buffer per store.
- Splits each store into bursts of up to 16 beats of 64 bits and streams buffer data with valid/ready and last-beat marking.
- Sits between the compute core's result buffers and the HP write-request/data channel.

---
 rtl/poststore_pkg.sv | 23 ++
 rtl/poststore_if.sv | 26 ++
 rtl/poststore_fifo.sv | 44 ++++
 rtl/poststore_writer.sv | 145 ++++++++++++++
 tb/tb_poststore_writer.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/poststore_pkg.sv
// poststore_pkg: shared types, constants and helpers for the poststore writer.
//   state_t   : request FSM states (IDLE, LOAD, REQ, WAIT)
//   BUF_READY : buffer state code meaning "results ready to drain"
//   burst_len : beats-1 of the next burst for a given number of remaining beats
package poststore_pkg;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 64;
    localparam int LEN_W      = 4;
    localparam int MAX_BURST  = 16;
    localparam int BEAT_BYTES = 8;

    localparam logic [2:0] BUF_READY = 3'b011;

    typedef enum logic [1:0] {IDLE, LOAD, REQ, WAIT} state_t;

    // Zero remaining beats maps to 0 so idle request fields read as 0.
    function automatic logic [LEN_W-1:0] burst_len(input logic [ADDR_W-1:0] n);
        return (n > ADDR_W'(MAX_BURST)) ? LEN_W'(MAX_BURST - 1) :
               (n == '0) ? '0 : LEN_W'(n - 1);
    endfunction

endpackage

// File: rtl/poststore_if.sv
// poststore_if: HP write-request and write-data channel bundle.
//   master : wr_req_addr/en/burst_length, hp_dataout/wvalid/wlast out; wr_req_ack, hp_wready in
//   slave  : mirror of master
interface poststore_if;
    import poststore_pkg::*;

    logic [ADDR_W-1:0] wr_req_addr;
    logic              wr_req_en;
    logic [LEN_W-1:0]  wr_req_burst_length;
    logic              wr_req_ack;
    logic [DATA_W-1:0] hp_dataout;
    logic              hp_wvalid;
    logic              hp_wlast;
    logic              hp_wready;

    modport master (
        output wr_req_addr, wr_req_en, wr_req_burst_length, hp_dataout, hp_wvalid, hp_wlast,
        input  wr_req_ack, hp_wready
    );

    modport slave (
        input  wr_req_addr, wr_req_en, wr_req_burst_length, hp_dataout, hp_wvalid, hp_wlast,
        output wr_req_ack, hp_wready
    );

endinterface

// File: rtl/poststore_fifo.sv
// poststore_fifo: synchronous DEPTH x WIDTH FIFO with occupancy count.
//   clk, rst : clock, synchronous active-high reset (empties the FIFO)
//   push/din : write din when push
//   pop      : advance head when pop
//   dout     : current head entry
//   count    : number of stored entries
module poststore_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp;
    logic [AW-1:0]    rp;

    assign dout = mem[rp];

    always_ff @(posedge clk) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wp] <= din;
                wp      <= wp + 1'b1;
            end
            if (pop) rp <= rp + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: rtl/poststore_writer.sv
// poststore_writer: drains a ping-pong result buffer to DDR over the HP write port.
//   clk, rst                   : clock, synchronous active-high reset
//   start_address/store_length : store byte address and beat count, sampled in LOAD
//   buffer0/1_state, use_select: buffer readiness and tie-break when both are ready
//   store_select/read/read_address, buffer_rd_data : buffer read side (1-cycle latency)
//   store_finish               : high when idle or done
//   hp (poststore_if.master)   : write-request and write-data channels
//   stall_cycles               : only with POSTSTORE_STALL_CNT_EN; cycles with wvalid & ~wready
module poststore_writer
    import poststore_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] start_address,
    input  logic [ADDR_W-1:0] store_length,
    input  logic [2:0]        buffer0_state,
    input  logic [2:0]        buffer1_state,
    input  logic              use_select,
    output logic              store_select,
    output logic              store_read,
    output logic [ADDR_W-1:0] store_read_address,
    input  logic [DATA_W-1:0] buffer_rd_data,
    output logic              store_finish,
    poststore_if.master       hp
`ifdef POSTSTORE_STALL_CNT_EN
    ,
    output logic [31:0]       stall_cycles
`endif
);

    state_t                  state;
    logic [ADDR_W-1:0]       reqcnt;
    logic [ADDR_W-1:0]       datacnt;
    logic [ADDR_W-1:0]       rd_rem;
    logic [ADDR_W-1:0]       outstanding;
    logic [LEN_W-1:0]        bcnt;
    logic                    mid;
    logic                    rd_pend;
    logic [DATA_W-1:0]       head;
    logic [$clog2(FIFO_DEPTH):0] count;

    logic              b0_rdy, b1_rdy, accept, ack, last, rd_go;
    logic [LEN_W-1:0]  cur;
    logic [ADDR_W-1:0] bsz, nxt_cnt;

    assign b0_rdy = buffer0_state == BUF_READY;
    assign b1_rdy = buffer1_state == BUF_READY;
    assign accept = hp.hp_wvalid & hp.hp_wready;
    assign ack    = hp.wr_req_en & hp.wr_req_ack;

    // Remaining beats in the current burst minus one; a fresh burst derives it from datacnt.
    assign cur  = mid ? bcnt : burst_len(datacnt);
    assign last = cur == '0;

    assign hp.hp_wvalid  = (count != '0) && (outstanding != '0);
    assign hp.hp_dataout = hp.hp_wvalid ? head : '0;
    assign hp.hp_wlast   = hp.hp_wvalid & last;

    assign bsz     = ADDR_W'(hp.wr_req_burst_length) + 1;
    assign nxt_cnt = reqcnt - bsz;

    // Reads already issued but not yet in the FIFO count against its free space.
    assign rd_go = (state == REQ || state == WAIT) && rd_rem != '0 &&
                   (32'(count) + 32'(rd_pend) + 32'(store_read) < 32'(FIFO_DEPTH));

    poststore_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rd_pend),
        .pop   (accept),
        .din   (buffer_rd_data),
        .dout  (head),
        .count (count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state                  <= IDLE;
            store_select           <= 1'b0;
            store_read             <= 1'b0;
            store_read_address     <= '0;
            store_finish           <= 1'b1;
            hp.wr_req_en           <= 1'b0;
            hp.wr_req_addr         <= '0;
            hp.wr_req_burst_length <= '0;
            reqcnt                 <= '0;
            datacnt                <= '0;
            rd_rem                 <= '0;
            outstanding            <= '0;
            bcnt                   <= '0;
            mid                    <= 1'b0;
            rd_pend                <= 1'b0;
        end else begin
            rd_pend    <= store_read;
            store_read <= rd_go;
            if (rd_go) rd_rem <= rd_rem - 1;
            if (store_read) store_read_address <= store_read_address + 2;
            if (accept) begin
                datacnt <= datacnt - 1;
                mid     <= !last;
                bcnt    <= cur - 1'b1;
            end
            outstanding <= outstanding + ADDR_W'(ack) - ADDR_W'(accept & last);
            case (state)
                IDLE: if (b0_rdy || b1_rdy) begin
                    store_select <= (b0_rdy && b1_rdy) ? use_select : b1_rdy;
                    state        <= LOAD;
                end
                LOAD: begin
                    hp.wr_req_addr         <= start_address;
                    hp.wr_req_burst_length <= burst_len(store_length);
                    hp.wr_req_en           <= store_length != '0;
                    reqcnt                 <= store_length;
                    datacnt                <= store_length;
                    rd_rem                 <= store_length;
                    store_read_address     <= '0;
                    store_finish           <= store_length == '0;
                    state                  <= (store_length == '0) ? IDLE : REQ;
                end
                REQ: if (ack) begin
                    hp.wr_req_addr         <= hp.wr_req_addr + bsz * ADDR_W'(BEAT_BYTES);
                    hp.wr_req_burst_length <= burst_len(nxt_cnt);
                    hp.wr_req_en           <= nxt_cnt != '0;
                    reqcnt                 <= nxt_cnt;
                    if (nxt_cnt == '0) state <= WAIT;
                end
                WAIT: if (accept && datacnt == 1) begin
                    store_finish <= 1'b1;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef POSTSTORE_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst || state == LOAD) stall_cycles <= '0;
        else if (hp.hp_wvalid && !hp.hp_wready && stall_cycles != '1) stall_cycles <= stall_cycles + 1;
    end
`endif

endmodule

// File: tb/tb_poststore_writer.sv
// tb_poststore_writer: directed self-checking bench for poststore_writer.
module tb_poststore_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] start_address, store_length, store_read_address;
    logic [2:0]  buffer0_state, buffer1_state;
    logic        use_select, store_select, store_read, store_finish;
    logic [63:0] buffer_rd_data;
`ifdef POSTSTORE_STALL_CNT_EN
    logic [31:0] stall_cycles;
`endif

    poststore_if bus ();

    poststore_writer dut (
        .clk                (clk),
        .rst                (rst),
        .start_address      (start_address),
        .store_length       (store_length),
        .buffer0_state      (buffer0_state),
        .buffer1_state      (buffer1_state),
        .use_select         (use_select),
        .store_select       (store_select),
        .store_read         (store_read),
        .store_read_address (store_read_address),
        .buffer_rd_data     (buffer_rd_data),
        .store_finish       (store_finish),
        .hp                 (bus)
`ifdef POSTSTORE_STALL_CNT_EN
        ,
        .stall_cycles       (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [63:0] bdata[$];
    logic        blast[$];
    logic [31:0] raddr[$];
    logic [3:0]  rlen[$];
    int          ack_delay = 0, en_wait = 0, reqs_acked = 0, bursts_done = 0;
    bit          tog = 0, en_ever = 0, stalled = 0, req_hold = 0;
    logic [63:0] sd;
    logic        sl;
    logic [31:0] ha;
    logic [3:0]  hl;

    function automatic logic [63:0] word(input logic s, input logic [31:0] a);
        return {s ? 32'hBBBB_1111 : 32'hAAAA_0000, a};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Buffer memory model with one-cycle read latency.
    always @(posedge clk) if (store_read) buffer_rd_data <= word(store_select, store_read_address);

    // HP slave: drives ack/wready for the coming edge, records handshakes, checks stall stability.
    always @(negedge clk) begin
        if (rst) begin
            stalled  = 0;
            req_hold = 0;
            en_wait  = 0;
        end else begin
            bus.hp_wready  = tog ? ~bus.hp_wready : 1'b1;
            bus.wr_req_ack = en_wait >= ack_delay;
            if (stalled) begin
                chk("stall_valid", 64'(bus.hp_wvalid), 64'd1);
                chk("stall_data", bus.hp_dataout, sd);
                chk("stall_last", 64'(bus.hp_wlast), 64'(sl));
            end
            if (req_hold) begin
                chk("req_en_hold", 64'(bus.wr_req_en), 64'd1);
                chk("req_addr_hold", 64'(bus.wr_req_addr), 64'(ha));
                chk("req_len_hold", 64'(bus.wr_req_burst_length), 64'(hl));
            end
            stalled  = bus.hp_wvalid && !bus.hp_wready;
            sd       = bus.hp_dataout;
            sl       = bus.hp_wlast;
            req_hold = bus.wr_req_en && !bus.wr_req_ack;
            ha       = bus.wr_req_addr;
            hl       = bus.wr_req_burst_length;
            if (bus.wr_req_en) en_ever = 1;
            if (bus.hp_wvalid && bus.hp_wready) begin
                chk("beat_after_req", 64'(bursts_done < reqs_acked), 64'd1);
                bdata.push_back(bus.hp_dataout);
                blast.push_back(bus.hp_wlast);
                if (bus.hp_wlast) bursts_done++;
            end
            if (bus.wr_req_en && bus.wr_req_ack) begin
                raddr.push_back(bus.wr_req_addr);
                rlen.push_back(bus.wr_req_burst_length);
                reqs_acked++;
                en_wait = 0;
            end else if (bus.wr_req_en) en_wait++;
        end
    end

    task automatic start_store(input logic [2:0] s0, input logic [2:0] s1, input logic us,
                               input logic [31:0] a, input logic [31:0] n);
        @(negedge clk);
        bdata.delete(); blast.delete(); raddr.delete(); rlen.delete();
        en_ever = 0; reqs_acked = 0; bursts_done = 0;
        start_address = a; store_length = n;
        buffer0_state = s0; buffer1_state = s1; use_select = us;
        @(negedge clk);
        buffer0_state = 3'b000; buffer1_state = 3'b000;
        repeat (2) @(negedge clk);
    endtask

    task automatic finish_store(input logic [31:0] n);
        int t = 0;
        while (!store_finish && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("finish_timeout", 64'(t < 3000), 64'd1);
        chk("finish_level", 64'(store_finish), 64'd1);
        chk("beats_at_finish", 64'(bdata.size()), 64'(n));
    endtask

    task automatic chk_beats(input logic s, input int n);
        for (int k = 0; k < n && k < bdata.size(); k++) begin
            chk($sformatf("beat%0d_data", k), bdata[k], word(s, 32'(2 * k)));
            chk($sformatf("beat%0d_last", k), 64'(blast[k]), 64'((k % 16) == 15 || k == n - 1));
        end
    endtask

    task automatic chk_req(input int i, input logic [31:0] a, input logic [3:0] l);
        if (i < raddr.size()) begin
            chk($sformatf("req%0d_addr", i), 64'(raddr[i]), 64'(a));
            chk($sformatf("req%0d_len", i), 64'(rlen[i]), 64'(l));
        end else chk($sformatf("req%0d_missing", i), 64'(raddr.size()), 64'(i + 1));
    endtask

    task automatic chk_reset_outputs(input string p);
        chk({p, "_store_select"}, 64'(store_select), 64'd0);
        chk({p, "_store_read"}, 64'(store_read), 64'd0);
        chk({p, "_read_addr"}, 64'(store_read_address), 64'd0);
        chk({p, "_store_finish"}, 64'(store_finish), 64'd1);
        chk({p, "_req_en"}, 64'(bus.wr_req_en), 64'd0);
        chk({p, "_req_addr"}, 64'(bus.wr_req_addr), 64'd0);
        chk({p, "_req_len"}, 64'(bus.wr_req_burst_length), 64'd0);
        chk({p, "_wvalid"}, 64'(bus.hp_wvalid), 64'd0);
        chk({p, "_wlast"}, 64'(bus.hp_wlast), 64'd0);
        chk({p, "_dataout"}, bus.hp_dataout, 64'd0);
    endtask

    initial begin
        int t;
        rst = 1'b1;
        start_address = '0; store_length = '0;
        buffer0_state = '0; buffer1_state = '0; use_select = 1'b0;
        bus.wr_req_ack = 1'b1; bus.hp_wready = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Single 16-beat store from buffer0.
        start_store(3'b011, 3'b000, 1'b0, 32'h1000, 32'd16);
        finish_store(32'd16);
        chk("t1_req_count", 64'(raddr.size()), 64'd1);
        chk_req(0, 32'h1000, 4'd15);
        chk_beats(1'b0, 16);

        // 40 beats split into 16 + 16 + 8.
        start_store(3'b011, 3'b000, 1'b0, 32'h2000, 32'd40);
        finish_store(32'd40);
        chk("t2_req_count", 64'(raddr.size()), 64'd3);
        chk_req(0, 32'h2000, 4'd15);
        chk_req(1, 32'h2080, 4'd15);
        chk_req(2, 32'h2100, 4'd7);
        chk_beats(1'b0, 40);

        // Both buffers ready, tie-break selects buffer1.
        start_store(3'b011, 3'b011, 1'b1, 32'h3000, 32'd5);
        chk("t3_store_select", 64'(store_select), 64'd1);
        finish_store(32'd5);
        chk_req(0, 32'h3000, 4'd4);
        chk_beats(1'b1, 5);

        // Toggling wready and 5-cycle delayed ack.
        tog = 1; ack_delay = 5;
        start_store(3'b011, 3'b000, 1'b0, 32'h4000, 32'd20);
        finish_store(32'd20);
        chk("t4_req_count", 64'(raddr.size()), 64'd2);
        chk_req(0, 32'h4000, 4'd15);
        chk_req(1, 32'h4080, 4'd3);
        chk_beats(1'b0, 20);
        tog = 0; ack_delay = 0;

        // Zero-length store issues no request.
        start_store(3'b011, 3'b000, 1'b0, 32'h5000, 32'd0);
        chk("t5_finish", 64'(store_finish), 64'd1);
        chk("t5_no_req", 64'(en_ever), 64'd0);
        chk("t5_no_beats", 64'(bdata.size()), 64'd0);

        // Reset mid-burst from buffer1, then a normal store.
        start_store(3'b000, 3'b011, 1'b0, 32'h7000, 32'd16);
        t = 0;
        while (bdata.size() < 7 && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("t6_reach_beat7", 64'(t < 500), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1 chk_reset_outputs("midrst");
        @(negedge clk);
        rst = 1'b0;
        start_store(3'b011, 3'b000, 1'b0, 32'h6000, 32'd3);
        finish_store(32'd3);
        chk("t6_req_count", 64'(raddr.size()), 64'd1);
        chk_req(0, 32'h6000, 4'd2);
        chk_beats(1'b0, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
